// File: rtl/fdre_delay_line.sv
// fdre_delay_line: WIDTH x DEPTH clock-enabled shift chain with sync reset to SRVAL, power-up INIT, dynamic tap and fill flag
module fdre_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter logic [WIDTH*DEPTH-1:0] INIT = '0,
  parameter logic [WIDTH-1:0] SRVAL = '0,
  parameter logic IS_C_INVERTED = 1'b0,
  parameter logic [WIDTH-1:0] IS_D_INVERTED = '0,
  parameter logic IS_R_INVERTED = 1'b0
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    A,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_LAST,
  output logic             FILL
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic clk, rst;
  logic [WIDTH*DEPTH-1:0] stage_q = INIT;
  logic [WIDTH*DEPTH-1:0] stage_d;
  logic [WIDTH*(DEPTH+1)-1:0] shift;
  logic [CW-1:0] cnt_q = '0;
  logic [CW-1:0] cnt_d;
  logic [AW-1:0] sel;
  assign clk = C ^ IS_C_INVERTED;
  assign rst = R ^ IS_R_INVERTED;
  always_comb begin
    shift = {stage_q, D ^ IS_D_INVERTED};
    stage_d = rst ? {DEPTH{SRVAL}} : CE ? shift[WIDTH*DEPTH-1:0] : stage_q;
    cnt_d = rst ? '0 : (CE && cnt_q != FULL) ? cnt_q + 1'b1 : cnt_q;
    sel = (A > LAST) ? LAST : A;
  end
  always_ff @(posedge clk) begin
    stage_q <= stage_d;
    cnt_q <= cnt_d;
  end
  assign Q = stage_q[sel*WIDTH +: WIDTH];
  assign Q_LAST = stage_q[WIDTH*DEPTH-1 -: WIDTH];
  assign FILL = (cnt_q == FULL);
endmodule

// File: tb/tb_fdre_delay_line.sv
// tb_fdre_delay_line: randomized and directed checks of four fdre_delay_line configurations against a queue-style model
module tb_fdre_delay_line;
  logic C = 1'b0, R0 = 1'b0, R1 = 1'b1, CE = 1'b0;
  logic [7:0] D = '0;
  logic [1:0] A = '0;
  logic [7:0] q [4];
  logic [7:0] ql [4];
  logic fl [4];
  logic [7:0] mdl [4][4];
  int mcnt [4];
  int mdep [4] = '{4, 4, 3, 1};
  int checks = 0, errors = 0;
  always #10 C = ~C;
  fdre_delay_line #(.WIDTH(8), .DEPTH(4), .INIT(32'h44332211), .SRVAL(8'hA5)) u0 (
    .C(C), .R(R0), .CE(CE), .D(D), .A(A), .Q(q[0]), .Q_LAST(ql[0]), .FILL(fl[0]));
  fdre_delay_line #(.WIDTH(8), .DEPTH(4), .SRVAL(8'h5A), .IS_C_INVERTED(1'b1),
    .IS_D_INVERTED(8'h0F), .IS_R_INVERTED(1'b1)) u1 (
    .C(C), .R(R1), .CE(CE), .D(D), .A(A), .Q(q[1]), .Q_LAST(ql[1]), .FILL(fl[1]));
  fdre_delay_line #(.WIDTH(8), .DEPTH(3), .SRVAL(8'h3C)) u2 (
    .C(C), .R(R0), .CE(CE), .D(D), .A(A), .Q(q[2]), .Q_LAST(ql[2]), .FILL(fl[2]));
  fdre_delay_line #(.WIDTH(8), .DEPTH(1), .SRVAL(8'hC3)) u3 (
    .C(C), .R(R0), .CE(CE), .D(D), .A(A[0]), .Q(q[3]), .Q_LAST(ql[3]), .FILL(fl[3]));

  task automatic upd(input int i, input logic r, input logic ce, input logic [7:0] d, input logic [7:0] sr);
    if (r) begin
      for (int k = 0; k < mdep[i]; k++) mdl[i][k] = sr;
      mcnt[i] = 0;
    end else if (ce) begin
      for (int k = mdep[i] - 1; k > 0; k--) mdl[i][k] = mdl[i][k-1];
      mdl[i][0] = d;
      if (mcnt[i] < mdep[i]) mcnt[i]++;
    end
  endtask

  task automatic cycle(input logic r0, input logic r1, input logic ce, input logic [7:0] d);
    R0 = r0; R1 = ~r1; CE = ce; D = d;
    @(posedge C); #1;
    upd(0, r0, ce, d, 8'hA5);
    upd(2, r0, ce, d, 8'h3C);
    upd(3, r0, ce, d, 8'hC3);
    @(negedge C); #1;
    upd(1, r1, ce, d ^ 8'h0F, 8'h5A);
  endtask

  task automatic test_reset;
    logic [31:0] init = 32'h44332211;
    for (int k = 0; k < 4; k++) mdl[0][k] = init[k*8 +: 8];
    for (int i = 1; i < 4; i++) for (int k = 0; k < 4; k++) mdl[i][k] = 8'h00;
    for (int i = 0; i < 4; i++) mcnt[i] = 0;
    #1;
    for (int t = 0; t < 4; t++) begin
      A = 2'(t); #1;
      checks++;
      if (q[0] !== init[t*8 +: 8]) begin errors++; $display("FAIL powerup_tap%0d got %h want %h", t, q[0], init[t*8 +: 8]); end
    end
    checks++;
    if (ql[0] !== 8'h44) begin errors++; $display("FAIL powerup_qlast got %h want 44", ql[0]); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fl[i] !== 1'b0) begin errors++; $display("FAIL powerup_fill%0d got %b want 0", i, fl[i]); end
    end
    A = 2'd0;
  endtask

  task automatic test_shift;
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'(i));
      checks++;
      if (fl[0] !== (i == 4)) begin errors++; $display("FAIL shift_fill_edge%0d got %b want %b", i, fl[0], i == 4); end
    end
    for (int n = 0; n < 4; n++) begin
      if (n > 0) cycle(1'b0, 1'b0, 1'b0, 8'hFF);
      A = 2'd0; #1;
      checks++;
      if (q[0] !== 8'h04 || ql[0] !== 8'h01 || fl[0] !== 1'b1) begin
        errors++; $display("FAIL shift_hold%0d got q=%h qlast=%h fill=%b want q=04 qlast=01 fill=1", n, q[0], ql[0], fl[0]);
      end
    end
  endtask

  task automatic test_reset_priority;
    cycle(1'b1, 1'b0, 1'b1, 8'h77);
    for (int t = 0; t < 4; t++) begin
      A = 2'(t); #1;
      checks++;
      if (q[0] !== 8'hA5) begin errors++; $display("FAIL rstprio_tap%0d got %h want a5", t, q[0]); end
    end
    checks++;
    if (fl[0] !== 1'b0) begin errors++; $display("FAIL rstprio_fill got %b want 0", fl[0]); end
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'($urandom));
      checks++;
      if (fl[0] !== (i == 4)) begin errors++; $display("FAIL rstprio_refill%0d got %b want %b", i, fl[0], i == 4); end
    end
  endtask

  task automatic test_reset_midfill;
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h11);
    cycle(1'b0, 1'b0, 1'b1, 8'h22);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'($urandom));
      checks++;
      if (fl[0] !== (i >= 4)) begin errors++; $display("FAIL midfill_shift%0d got %b want %b", i, fl[0], i >= 4); end
    end
  endtask

  task automatic test_inversions;
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    A = 2'd0; R0 = 1'b0; R1 = 1'b1; CE = 1'b1; D = 8'h30;
    @(posedge C); #1;
    upd(0, 1'b0, 1'b1, 8'h30, 8'hA5);
    upd(2, 1'b0, 1'b1, 8'h30, 8'h3C);
    upd(3, 1'b0, 1'b1, 8'h30, 8'hC3);
    checks++;
    if (q[1] !== 8'h0F) begin errors++; $display("FAIL inv_posedge_hold got %h want 0f", q[1]); end
    @(negedge C); #1;
    upd(1, 1'b0, 1'b1, 8'h3F, 8'h5A);
    checks++;
    if (q[1] !== 8'h3F) begin errors++; $display("FAIL inv_stage0 got %h want 3f", q[1]); end
    cycle(1'b0, 1'b1, 1'b1, 8'h44);
    for (int t = 0; t < 4; t++) begin
      A = 2'(t); #1;
      checks++;
      if (q[1] !== 8'h5A) begin errors++; $display("FAIL inv_reset_tap%0d got %h want 5a", t, q[1]); end
    end
    checks++;
    if (fl[1] !== 1'b0) begin errors++; $display("FAIL inv_reset_fill got %b want 0", fl[1]); end
  endtask

  task automatic test_tap_oob;
    cycle(1'b0, 1'b0, 1'b1, 8'h10);
    cycle(1'b0, 1'b0, 1'b1, 8'h20);
    cycle(1'b0, 1'b0, 1'b1, 8'h30);
    A = 2'd3; #1;
    checks++;
    if (q[2] !== 8'h10 || ql[2] !== 8'h10) begin errors++; $display("FAIL oob_depth3 got q=%h qlast=%h want 10", q[2], ql[2]); end
    for (int t = 0; t < 2; t++) begin
      A = 2'(t); #1;
      checks++;
      if (q[3] !== 8'h30 || ql[3] !== 8'h30) begin errors++; $display("FAIL depth1_a%0d got q=%h qlast=%h want 30", t, q[3], ql[3]); end
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 300; n++) begin
      cycle($urandom_range(15) == 0, $urandom_range(15) == 0, $urandom_range(3) != 0, 8'($urandom));
      for (int t = 0; t < 4; t++) begin
        A = 2'(t); #1;
        for (int i = 0; i < 4; i++) begin
          int e = (t < mdep[i]) ? t : mdep[i] - 1;
          checks++;
          if (q[i] !== mdl[i][e]) begin errors++; $display("FAIL rand_tap u%0d a%0d cyc%0d got %h want %h", i, t, n, q[i], mdl[i][e]); end
        end
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ql[i] !== mdl[i][mdep[i]-1] || fl[i] !== (mcnt[i] == mdep[i])) begin
          errors++; $display("FAIL rand_last u%0d cyc%0d got qlast=%h fill=%b want qlast=%h fill=%b",
            i, n, ql[i], fl[i], mdl[i][mdep[i]-1], mcnt[i] == mdep[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_shift;
    test_reset_priority;
    test_reset_midfill;
    test_inversions;
    test_tap_oob;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
